// File: rtl/board_io_pkg.sv
// Shared types and defaults for the board I/O controller.
// Holds the debounce FSM state enum and the heartbeat counter width.
package board_io_pkg;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_CNT_HI,
        ST_HIGH,
        ST_CNT_LO
    } deb_state_t;

    localparam int DEF_SW_W        = 16;
    localparam int DEF_LED_W       = 16;
    localparam int DEF_NBTN        = 2;
    localparam int DEF_DEB_CYCLES  = 1000000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int HB_BITS         = 25;

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// One push-button: synchroniser chain, then a four-state debounce FSM
// with registered level and one-cycle rise/fall pulses.
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk0,
    input  logic rst0,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    deb_state_t             state;
    logic                   din;

    assign din = sync[SYNC_STAGES-1];

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            sync  <= '0;
            cnt   <= '0;
            state <= ST_LOW;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                ST_LOW: begin
                    if (din) begin
                        state <= ST_CNT_HI;
                        cnt   <= '0;
                    end
                end
                ST_CNT_HI: begin
                    if (!din) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!din) begin
                        state <= ST_CNT_LO;
                        cnt   <= '0;
                    end
                end
                ST_CNT_LO: begin
                    // bounce back high: stay pressed, no pulse
                    if (din) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_LOW;
            endcase
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O: synchronised switches, debounced buttons, registered LEDs.
// Define BOARD_IO_HEARTBEAT_EN to drive the top LED as a heartbeat.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int SW_W        = DEF_SW_W,
    parameter int LED_W       = DEF_LED_W,
    parameter int NBTN        = DEF_NBTN,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [NBTN-1:0]  btn_in,
    input  logic [LED_W-1:0] led_in,
    output logic [SW_W-1:0]  sw_out,
    output logic [NBTN-1:0]  btn_level,
    output logic [NBTN-1:0]  btn_rise,
    output logic [NBTN-1:0]  btn_fall,
    output logic [LED_W-1:0] led_out
);

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_pipe;

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            sw_pipe <= '0;
        end else begin
            sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign sw_out = sw_pipe[SYNC_STAGES-1];

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_deb (
            .clk0  (clk0),
            .rst0  (rst0),
            .btn_in(btn_in[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

`ifdef BOARD_IO_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_cnt;
    logic               unused_led_msb;

    assign unused_led_msb = led_in[LED_W-1];

    // top LED flips each time the counter wraps
    always_ff @(posedge clk0) begin
        if (!rst0) begin
            hb_cnt  <= '0;
            led_out <= '0;
        end else begin
            hb_cnt               <= hb_cnt + 1'b1;
            led_out[LED_W-2:0]   <= led_in[LED_W-2:0];
            if (&hb_cnt) begin
                led_out[LED_W-1] <= ~led_out[LED_W-1];
            end
        end
    end
`else
    always_ff @(posedge clk0) begin
        if (!rst0) begin
            led_out <= '0;
        end else begin
            led_out <= led_in;
        end
    end
`endif

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl (DEB_CYCLES=4, SYNC_STAGES=2).
// Expectations are queued when stimulus is driven and checked when due.
module tb_board_io_ctrl;

    localparam int SW_W  = 16;
    localparam int LED_W = 16;
    localparam int NBTN  = 2;
    localparam int LAT   = 7;

`ifdef BOARD_IO_HEARTBEAT_EN
    localparam logic [15:0] LED_MASK = 16'h7FFF;
`else
    localparam logic [15:0] LED_MASK = 16'hFFFF;
`endif

    logic             clk0 = 1'b0;
    logic             rst0;
    logic [SW_W-1:0]  sw_in;
    logic [NBTN-1:0]  btn_in;
    logic [LED_W-1:0] led_in;
    logic [SW_W-1:0]  sw_out;
    logic [NBTN-1:0]  btn_level;
    logic [NBTN-1:0]  btn_rise;
    logic [NBTN-1:0]  btn_fall;
    logic [LED_W-1:0] led_out;

    always #5 clk0 = ~clk0;

    board_io_ctrl #(
        .SW_W       (SW_W),
        .LED_W      (LED_W),
        .NBTN       (NBTN),
        .DEB_CYCLES (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk0     (clk0),
        .rst0     (rst0),
        .sw_in    (sw_in),
        .btn_in   (btn_in),
        .led_in   (led_in),
        .sw_out   (sw_out),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .led_out  (led_out)
    );

    typedef struct {
        logic [15:0] sw;
        logic [15:0] led;
        logic [15:0] exp_sw;
        logic [15:0] exp_led;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] val;
    } word_exp_t;

    typedef struct {
        int         due;
        logic [1:0] rise;
        logic [1:0] fall;
    } btn_exp_t;

    word_exp_t sw_q[$];
    word_exp_t led_q[$];
    btn_exp_t  btn_q[$];
    vec_t      tbl[8];

    int         cyc;
    int         checks;
    int         errors;
    logic [1:0] exp_level;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle(input logic was_rst);
        logic [1:0] er;
        logic [1:0] ef;
        er = '0;
        ef = '0;
        for (int i = btn_q.size() - 1; i >= 0; i--) begin
            if (btn_q[i].due == cyc) begin
                er |= btn_q[i].rise;
                ef |= btn_q[i].fall;
                btn_q.delete(i);
            end
        end
        if (was_rst) exp_level = '0;
        else         exp_level = (exp_level | er) & ~ef;
        chk("btn_rise", 32'(btn_rise), 32'(er));
        chk("btn_fall", 32'(btn_fall), 32'(ef));
        chk("btn_level", 32'(btn_level), 32'(exp_level));
        if (sw_q.size() > 0 && sw_q[0].due == cyc) begin
            chk("sw_out", 32'(sw_out), 32'(sw_q[0].val));
            void'(sw_q.pop_front());
        end
        if (led_q.size() > 0 && led_q[0].due == cyc) begin
            chk("led_out", 32'(led_out & LED_MASK),
                32'(led_q[0].val & LED_MASK));
            void'(led_q.pop_front());
        end
    endtask

    task automatic step();
        logic r;
        r = rst0;
        @(posedge clk0);
        #1;
        cyc++;
        check_cycle(!r);
    endtask

    task automatic push_btn(input logic [1:0] r, input logic [1:0] f);
        btn_exp_t e;
        e.due  = cyc + LAT;
        e.rise = r;
        e.fall = f;
        btn_q.push_back(e);
    endtask

    initial begin
        word_exp_t we;
        logic [15:0] v_sw [8];
        logic [15:0] v_led[8];

        v_sw  = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h5A3C,
                  16'h8001, 16'h7FFE, 16'h1357, 16'hA5C3};
        v_led = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000,
                  16'h0001, 16'hCAFE, 16'h7FFF, 16'h1234};
        for (int i = 0; i < 8; i++) begin
            tbl[i].sw      = v_sw[i];
            tbl[i].led     = v_led[i];
            tbl[i].exp_sw  = v_sw[i];
            tbl[i].exp_led = v_led[i];
        end

        cyc       = 0;
        checks    = 0;
        errors    = 0;
        exp_level = '0;

        rst0   = 1'b0;
        sw_in  = 16'hFFFF;
        btn_in = 2'b11;
        led_in = 16'hFFFF;
        repeat (2) begin
            step();
            chk("rst_sw_out", 32'(sw_out), 32'h0);
            chk("rst_led_out", 32'(led_out), 32'h0);
        end

        rst0   = 1'b1;
        sw_in  = '0;
        btn_in = '0;
        led_in = '0;
        repeat (3) step();

        for (int i = 0; i < 8; i++) begin
            sw_in  = tbl[i].sw;
            led_in = tbl[i].led;
            we.due = cyc + 2;
            we.val = tbl[i].exp_sw;
            sw_q.push_back(we);
            we.due = cyc + 1;
            we.val = tbl[i].exp_led;
            led_q.push_back(we);
            step();
        end
        repeat (3) step();

        btn_in[0] = 1'b1;
        push_btn(2'b01, 2'b00);
        repeat (12) step();
        btn_in[0] = 1'b0;
        push_btn(2'b00, 2'b01);
        repeat (10) step();

        btn_in[1] = 1'b1;
        repeat (3) step();
        btn_in[1] = 1'b0;
        repeat (10) step();

        btn_in[0] = 1'b1;
        repeat (5) step();
        rst0 = 1'b0;
        step();
        rst0 = 1'b1;
        push_btn(2'b01, 2'b00);
        repeat (10) step();
        btn_in[0] = 1'b0;
        push_btn(2'b00, 2'b01);
        repeat (10) step();

        btn_in = 2'b11;
        push_btn(2'b11, 2'b00);
        repeat (10) step();
        btn_in = 2'b00;
        push_btn(2'b00, 2'b11);
        repeat (10) step();

        chk("sb_drained", 32'(sw_q.size() + led_q.size() + btn_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
